alu_issue_arbiter: RTL

- Shares one external ALU_32b instance between two requesters: requester 0 is the main integer pipeline, requester 1 is the branch/address unit.
- Arbitrates between them, registers the winning micro-op onto the ALU inputs and captures ALU_OUT one cycle later.
- Holds the result, with its tag and requester ID, until the writeback consumer accepts it.
- Sits between decode/issue and writeback; the ALU itself stays combinational.

---
 rtl/alu_issue_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/alu_issue_arbiter.sv
// Arbitrates two requesters onto one shared combinational ALU and holds each
// captured result, with its tag and requester ID, until writeback accepts it.
module alu_issue_arbiter #(
  parameter int TAG_W      = 4,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 16,
  localparam int UOP_W     = 7 + 3 + 1 + 5 + 12 + 20 + 32 + 32 + 32
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [1:0]           REQ_VALID,
  output logic [1:0]           REQ_READY,
  input  logic [2*UOP_W-1:0]   REQ_UOP,
  input  logic [2*TAG_W-1:0]   REQ_TAG,
  output logic [UOP_W-1:0]     ALU_UOP,
  input  logic [31:0]          ALU_OUT,
  output logic                 ALU_ACTIVE,
  output logic                 RES_VALID,
  input  logic                 RES_READY,
  output logic [31:0]          RES_DATA,
  output logic [TAG_W-1:0]     RES_TAG,
  output logic                 RES_ID,
  output logic [CNT_W-1:0]     DONE_CNT,
  output logic                 BUSY
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t            state, next_state;
  logic [1:0]        gnt;
  logic              gnt_idx;
  logic              accept;
  logic              accept_win;
  logic              last_gnt;
  logic [TAG_W-1:0]  hold_tag;
  logic              hold_id;

  // Holding off grants while reset is asserted keeps every output quiet in reset.
  assign accept_win = RESET_N && ((state == IDLE) || ((state == HOLD) && RES_READY));
  assign gnt_idx    = gnt[1];
  assign accept     = |gnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    gnt        = 2'b00;
    next_state = state;
    if (accept_win) begin
      case (REQ_VALID)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ((FIXED_PRIO != 0) || last_gnt) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    case (state)
      IDLE:    if (accept) next_state = EXEC;
      EXEC:    next_state = HOLD;
      HOLD:    if (RES_READY) next_state = accept ? EXEC : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ALU_UOP is left alone in IDLE so the last operands stay on the ALU inputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ALU_UOP  <= '0;
      hold_tag <= '0;
      hold_id  <= 1'b0;
      last_gnt <= 1'b1;
      RES_DATA <= '0;
      RES_TAG  <= '0;
      RES_ID   <= 1'b0;
      DONE_CNT <= '0;
    end else begin
      if (accept) begin
        ALU_UOP  <= gnt_idx ? REQ_UOP[2*UOP_W-1:UOP_W] : REQ_UOP[UOP_W-1:0];
        hold_tag <= gnt_idx ? REQ_TAG[2*TAG_W-1:TAG_W] : REQ_TAG[TAG_W-1:0];
        hold_id  <= gnt_idx;
        last_gnt <= gnt_idx;
      end
      if (state == EXEC) begin
        RES_DATA <= ALU_OUT;
        RES_TAG  <= hold_tag;
        RES_ID   <= hold_id;
      end
      if ((state == HOLD) && RES_READY) DONE_CNT <= DONE_CNT + CNT_W'(1);
    end
  end

  assign REQ_READY  = gnt;
  assign RES_VALID  = (state == HOLD);
  assign ALU_ACTIVE = (state == EXEC);
  assign BUSY       = (state != IDLE);

endmodule
